// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point accumulator: word format
// {sign, exponent, fraction}, the controller state type and field helpers.
package fp_pkg;

  localparam int unsigned NB_MANT  = 8;
  localparam int unsigned NB_EXP   = 4;
  localparam int unsigned NB_TOTAL = 1 + NB_EXP + NB_MANT;
  localparam int unsigned BIAS     = 7;

  typedef logic [NB_TOTAL-1:0] word_t;
  typedef logic [NB_EXP-1:0]   exp_t;
  typedef logic [NB_MANT-1:0]  frac_t;
  // Mantissa with the hidden bit.
  typedef logic [NB_MANT:0]    mant_t;
  // Adder result: carry + hidden + fraction.
  typedef logic [NB_MANT+1:0]  sum_t;

  typedef enum logic [2:0] {
    StIdle,
    StAlign,
    StAdd,
    StNorm,
    StDone
  } state_e;

  function automatic logic get_sign(word_t w);
    return w[NB_TOTAL-1];
  endfunction

  function automatic exp_t get_exp(word_t w);
    return w[NB_TOTAL-2 -: NB_EXP];
  endfunction

  function automatic frac_t get_frac(word_t w);
    return w[NB_MANT-1:0];
  endfunction

  function automatic word_t pack_word(logic s, exp_t e, frac_t f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Handshake bundle between the multiplier-side producer (master) and the
// accumulator (slave).
interface fp_accumulator_if;
  import fp_pkg::*;

  logic  CLEAR;
  word_t IN_DATA;
  logic  IN_VALID;
  logic  IN_LAST;
  logic  IN_READY;
  word_t OUT_DATA;
  logic  OUT_VALID;
  logic  OUT_OVF;

  modport master (
    output CLEAR, IN_DATA, IN_VALID, IN_LAST,
    input  IN_READY, OUT_DATA, OUT_VALID, OUT_OVF
  );

  modport slave (
    input  CLEAR, IN_DATA, IN_VALID, IN_LAST,
    output IN_READY, OUT_DATA, OUT_VALID, OUT_OVF
  );

endinterface

// File: rtl/fp_align.sv
// Combinational alignment: picks the larger-magnitude operand, and shifts the
// smaller mantissa right by the exponent difference. Zero words (E=0) act as
// mantissa 0 whatever their fraction holds.
module fp_align
  import fp_pkg::*;
(
  input  word_t a_i,
  input  word_t b_i,
  output logic  big_sign_o,
  output exp_t  big_exp_o,
  output mant_t big_mant_o,
  output mant_t small_mant_o,
  output logic  eff_sub_o
);

  logic                     a_zero, b_zero, a_big;
  logic [NB_EXP+NB_MANT-1:0] key_a, key_b;
  mant_t                    mant_a, mant_b, small_mant;
  exp_t                     small_exp, diff;

  // Magnitude compare on {E,M}, swap, then shift the smaller operand.
  always_comb begin
    a_zero = (get_exp(a_i) == '0);
    b_zero = (get_exp(b_i) == '0);
    key_a  = a_zero ? '0 : {get_exp(a_i), get_frac(a_i)};
    key_b  = b_zero ? '0 : {get_exp(b_i), get_frac(b_i)};
    mant_a = a_zero ? '0 : {1'b1, get_frac(a_i)};
    mant_b = b_zero ? '0 : {1'b1, get_frac(b_i)};
    a_big  = (key_a >= key_b);

    big_sign_o = a_big ? get_sign(a_i) : get_sign(b_i);
    big_exp_o  = a_big ? get_exp(a_i)  : get_exp(b_i);
    big_mant_o = a_big ? mant_a : mant_b;
    small_mant = a_big ? mant_b : mant_a;
    small_exp  = a_big ? get_exp(b_i) : get_exp(a_i);
    diff       = big_exp_o - small_exp;

    // Beyond NB_MANT+1 positions nothing of the smaller operand survives.
    if (int'(diff) > int'(NB_MANT) + 1) begin
      small_mant_o = '0;
    end else begin
      small_mant_o = small_mant >> diff;
    end

    eff_sub_o = get_sign(a_i) ^ get_sign(b_i);
  end

endmodule

// File: rtl/fp_accumulator.sv
// Multi-cycle floating-point accumulator: sums a stream of {sign, E, M} words
// (bias 7, hidden 1, truncating) and emits the total on the last element.
// Optional macro FP_ACC_SATURATE_EN: exponent overflow saturates to max
// magnitude and raises OUT_OVF; otherwise the exponent wraps and OUT_OVF is 0.
module fp_accumulator
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fp_accumulator_if.slave  bus
);

`ifdef FP_ACC_SATURATE_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  state_e state_q, state_d;
  word_t  acc_q, acc_d;
  word_t  op_q, op_d;
  logic   last_q, last_d;
  logic   sign_q, sign_d;
  exp_t   exp_q, exp_d;
  mant_t  big_q, big_d;
  mant_t  small_q, small_d;
  logic   sub_q, sub_d;
  sum_t   sum_q, sum_d;
  logic   ovf_q, ovf_d;
  word_t  out_data_q, out_data_d;

  logic   al_sign, al_sub;
  exp_t   al_exp;
  mant_t  al_big, al_small;
  word_t  res_word;
  logic   norm_done;

  fp_align u_align (
    .a_i          (op_q),
    .b_i          (acc_q),
    .big_sign_o   (al_sign),
    .big_exp_o    (al_exp),
    .big_mant_o   (al_big),
    .small_mant_o (al_small),
    .eff_sub_o    (al_sub)
  );

  // Result word seen by DONE; a zero sum always encodes as +0.
  always_comb begin
    res_word  = (sum_q == '0) ? '0 : pack_word(sign_q, exp_q, sum_q[NB_MANT-1:0]);
    norm_done = (sum_q == '0) || sum_q[NB_MANT+1] || sum_q[NB_MANT] ||
                (exp_q <= exp_t'(1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; CLEAR aborts from any state.
  always_comb begin
    state_d = state_q;
    if (bus.CLEAR) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (bus.IN_VALID) state_d = StAlign;
        StAlign: state_d = StAdd;
        StAdd:   state_d = StNorm;
        StNorm:  if (norm_done) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state; the total is visible during the DONE pulse.
  always_comb begin
    bus.IN_READY  = (state_q == StIdle);
    bus.OUT_VALID = (state_q == StDone) && last_q && !bus.CLEAR;
    bus.OUT_DATA  = bus.OUT_VALID ? res_word : out_data_q;
    bus.OUT_OVF   = SatEn ? ovf_q : 1'b0;
  end

  // Datapath register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      op_q       <= '0;
      last_q     <= 1'b0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      big_q      <= '0;
      small_q    <= '0;
      sub_q      <= 1'b0;
      sum_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      acc_q      <= acc_d;
      op_q       <= op_d;
      last_q     <= last_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      big_q      <= big_d;
      small_q    <= small_d;
      sub_q      <= sub_d;
      sum_q      <= sum_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
    end
  end

  // Datapath next-state: latch, align, add, normalize one step per cycle, commit.
  always_comb begin
    acc_d      = acc_q;
    op_d       = op_q;
    last_d     = last_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    big_d      = big_q;
    small_d    = small_q;
    sub_d      = sub_q;
    sum_d      = sum_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;

    if (bus.CLEAR) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.IN_VALID) begin
            op_d   = bus.IN_DATA;
            last_d = bus.IN_LAST;
          end
        end
        StAlign: begin
          sign_d  = al_sign;
          exp_d   = al_exp;
          big_d   = al_big;
          small_d = al_small;
          sub_d   = al_sub;
        end
        StAdd: begin
          // Alignment guarantees big >= small, so subtraction never borrows.
          if (sub_q) begin
            sum_d = {1'b0, big_q} - {1'b0, small_q};
          end else begin
            sum_d = {1'b0, big_q} + {1'b0, small_q};
          end
        end
        StNorm: begin
          if (sum_q == '0) begin
            sign_d = 1'b0;
            exp_d  = '0;
          end else if (sum_q[NB_MANT+1]) begin
            if (SatEn && (exp_q == '1)) begin
              sum_d = {1'b0, {(NB_MANT+1){1'b1}}};
              ovf_d = 1'b1;
            end else begin
              // Without saturation the exponent wraps modulo 2^NB_EXP.
              sum_d = sum_q >> 1;
              exp_d = exp_q + exp_t'(1);
            end
          end else if (!sum_q[NB_MANT]) begin
            if (exp_q <= exp_t'(1)) begin
              // Underflow below the smallest normal: flush to +0.
              sum_d  = '0;
              sign_d = 1'b0;
              exp_d  = '0;
            end else begin
              sum_d = sum_q << 1;
              exp_d = exp_q - exp_t'(1);
            end
          end
        end
        StDone: begin
          if (last_q) begin
            acc_d      = '0;
            ovf_d      = 1'b0;
            out_data_d = res_word;
          end else begin
            acc_d = res_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
